// File: rtl/vga_fb_scanout_if.sv
// Display-port link between the VGA scan-out engine and the dual-port frame-buffer RAM.
// The read data arrives one clk after the word address.
interface vga_fb_scanout_if;
    logic [14:0] vga_addr;
    logic [15:0] vga_data;

    modport master (output vga_addr, input  vga_data);
    modport slave  (input  vga_addr, output vga_data);
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA scan-out engine: 1 bpp frame buffer (16 pixels/word) to hsync/vsync/RGB332.
// 50 MHz clk with an internal /2 pixel enable; every output is delayed one pixel from the counters.
module vga_fb_scanout #(
    parameter int unsigned H_VIS          = 640,
    parameter int unsigned H_FP           = 16,
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BP           = 48,
    parameter int unsigned V_VIS          = 480,
    parameter int unsigned V_FP           = 10,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BP           = 33,
    parameter logic [14:0] FB_BASE        = 15'h0000,
    parameter int unsigned WORDS_PER_LINE = H_VIS / 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vga_fb_scanout_if.master        fb,
    input  logic [7:0]              fg_color,
    input  logic [7:0]              bg_color,
    output logic                    hsync,
    output logic                    vsync,
    output logic [7:0]              rgb,
    output logic                    frame_start
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned AW      = 15;
    localparam int unsigned DW      = 16;

    logic          pe;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [AW-1:0] line_base;
    logic [AW-1:0] addr_q;
    logic          fetch_q;
    logic [DW-1:0] hold;
    logic [DW-1:0] shifter;
    logic          video_ok;

    logic          h_last_c;
    logic          v_last_c;
    logic          hs_c;
    logic          vs_c;
    logic          vis_c;
    logic          word_fetch_c;
    logic          pre_fetch_c;
    logic          load_c;
    logic          pix_bit_c;
    logic [AW-1:0] next_base_c;

    assign fb.vga_addr = addr_q;

    // Timing decode and fetch scheduling from the current counter values.
    always_comb begin
        h_last_c     = 1'b0;
        v_last_c     = 1'b0;
        hs_c         = 1'b1;
        vs_c         = 1'b1;
        vis_c        = 1'b0;
        word_fetch_c = 1'b0;
        pre_fetch_c  = 1'b0;
        load_c       = 1'b0;
        pix_bit_c    = 1'b0;
        next_base_c  = FB_BASE;

        h_last_c = (hcount == HW'(H_TOTAL - 1));
        v_last_c = (vcount == VW'(V_TOTAL - 1));
        hs_c     = !((hcount >= HW'(H_VIS + H_FP)) && (hcount < HW'(H_VIS + H_FP + H_SYNC)));
        vs_c     = !((vcount >= VW'(V_VIS + V_FP)) && (vcount < VW'(V_VIS + V_FP + V_SYNC)));
        vis_c    = (hcount < HW'(H_VIS)) && (vcount < VW'(V_VIS));

        // Words 1..N-1 go out 8 pixels before they are needed; word 0 is prefetched on the previous line.
        word_fetch_c = (vcount < VW'(V_VIS)) && (hcount[3:0] == 4'd8) && (hcount < HW'(H_VIS - 8));
        pre_fetch_c  = (hcount == HW'(H_TOTAL - 8)) && ((vcount < VW'(V_VIS - 1)) || v_last_c);
        next_base_c  = v_last_c ? FB_BASE : AW'(line_base + AW'(WORDS_PER_LINE));

        // The shifter holds the word already advanced by one, so a load pixel comes straight from hold.
        load_c    = vis_c && (hcount[3:0] == 4'd0);
        pix_bit_c = load_c ? hold[DW-1] : shifter[DW-1];
    end

    // Pixel enable and raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe     <= 1'b0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            pe <= ~pe;
            if (pe) begin
                if (h_last_c) begin
                    hcount <= '0;
                    vcount <= v_last_c ? '0 : VW'(vcount + VW'(1));
                end else begin
                    hcount <= HW'(hcount + HW'(1));
                end
            end
        end
    end

    // Address generation and read-data capture; data is taken at the pe after the fetch, once the RAM latency has elapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= FB_BASE;
            line_base <= FB_BASE;
            fetch_q   <= 1'b0;
            hold      <= '0;
        end else if (pe) begin
            if (pre_fetch_c) begin
                addr_q <= next_base_c;
            end else if (word_fetch_c) begin
                addr_q <= AW'(addr_q + AW'(1));
            end
            fetch_q <= pre_fetch_c | word_fetch_c;
            if (fetch_q) begin
                hold <= fb.vga_data;
            end
            if (h_last_c && v_last_c) begin
                line_base <= FB_BASE;
            end else if (h_last_c && (vcount < VW'(V_VIS - 1))) begin
                line_base <= AW'(line_base + AW'(WORDS_PER_LINE));
            end
        end
    end

    // Pixel shifter, MSB is the leftmost pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter <= '0;
        end else if (pe) begin
            shifter <= load_c ? {hold[DW-2:0], 1'b0} : {shifter[DW-2:0], 1'b0};
        end
    end

    // Output registers; video_ok arms on the last pixel of the first frame so the partial frame stays black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= '0;
            frame_start <= 1'b0;
            video_ok    <= 1'b0;
        end else if (pe) begin
            hsync       <= hs_c;
            vsync       <= vs_c;
            rgb         <= (vis_c && video_ok) ? (pix_bit_c ? fg_color : bg_color) : 8'h00;
            frame_start <= (hcount == '0) && (vcount == '0);
            if (h_last_c && v_last_c) begin
                video_ok <= 1'b1;
            end
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule
